// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: owner FSM encoding,
// grant vector type, default starvation limit and a saturating-increment helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_state_e;

    typedef struct packed {
        logic i;
        logic d;
    } grant_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int STAT_WIDTH           = 32;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Priority decision for the shared RAM port: data wins conflicts until the
// instruction side has lost STARVE_LIMIT conflicts in a row.
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    output grant_t gnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       force_i;

    always_comb begin
        force_i = (starve_cnt_q >= LIMIT);
        gnt     = '0;
        if (!reset) begin
            gnt.i = i_req & (~d_req | force_i);
            gnt.d = d_req & ~gnt.i;
        end

        // Only a conflict the instruction side loses moves the counter up.
        starve_cnt_d = starve_cnt_q;
        if (gnt.i) begin
            starve_cnt_d = '0;
        end else if (i_req && d_req && !reset && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a single combinational-read RAM port with registered
// read responses. Define MEM_ARB_STATS_EN to enable the grant/conflict counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wEn,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [STAT_WIDTH-1:0] stat_i_grants,
    output logic [STAT_WIDTH-1:0] stat_d_grants,
    output logic [STAT_WIDTH-1:0] stat_conflicts
);

    grant_t gnt;

    owner_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb_prio (
        .clock (clock),
        .reset (reset),
        .i_req (i_req),
        .d_req (d_req),
        .gnt   (gnt)
    );

    assign i_gnt     = gnt.i;
    assign d_gnt     = gnt.d;
    assign ram_wEn   = d_gnt & d_we;
    assign ram_wdata = d_wdata;

    always_comb begin
        ram_addr = '0;
        if (i_gnt) begin
            ram_addr = i_addr;
        end else if (d_gnt) begin
            ram_addr = d_addr;
        end
    end

    // The state remembers who owned the port last cycle, which is exactly who gets rvalid now.
    always_comb begin
        state_d   = IDLE;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (i_gnt) begin
            state_d   = OWN_I;
            i_rdata_d = ram_rdata;
        end else if (d_gnt && !d_we) begin
            state_d   = OWN_D;
            d_rdata_d = ram_rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_rvalid = (state_q == OWN_I);
    assign d_rvalid = (state_q == OWN_D);
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_i_q, stat_i_d;
    logic [STAT_WIDTH-1:0] stat_d_q, stat_d_d;
    logic [STAT_WIDTH-1:0] stat_c_q, stat_c_d;

    always_comb begin
        stat_i_d = i_gnt ? sat_inc(stat_i_q) : stat_i_q;
        stat_d_d = d_gnt ? sat_inc(stat_d_q) : stat_d_q;
        stat_c_d = (i_req && d_req && !reset) ? sat_inc(stat_c_q) : stat_c_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_i_q <= '0;
            stat_d_q <= '0;
            stat_c_q <= '0;
        end else begin
            stat_i_q <= stat_i_d;
            stat_d_q <= stat_d_d;
            stat_c_q <= stat_c_d;
        end
    end

    assign stat_i_grants  = stat_i_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_conflicts = stat_c_q;
`else
    assign stat_i_grants  = '0;
    assign stat_d_grants  = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/responses from a
// reference model, an independent monitor pops and compares every cycle.
module tb_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int LIMIT = 4;

    logic          clock;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wEn;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [31:0]   stat_i_grants;
    logic [31:0]   stat_d_grants;
    logic [31:0]   stat_conflicts;

    mem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .ram_addr       (ram_addr),
        .ram_wEn        (ram_wEn),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .stat_i_grants  (stat_i_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_conflicts (stat_conflicts)
    );

    typedef struct {
        bit            i;
        bit            d;
        logic [AW-1:0] addr;
        bit            wen;
        logic [DW-1:0] wdata;
    } gnt_exp_t;

    typedef struct {
        bit            is_i;
        logic [DW-1:0] data;
        int            due;
    } resp_exp_t;

    gnt_exp_t  gnt_q[$];
    resp_exp_t resp_q[$];

    int            tests_run;
    int            tests_failed;
    int            stim_cycle;
    bit            monitor_en;
    int            lost_streak;
    logic [DW-1:0] last_i;
    logic [DW-1:0] last_d;
    int            n_i;
    int            n_d;
    int            n_conf;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, stim_cycle);
        end
    endtask

    // One clock cycle of stimulus; the model decides who should win from the
    // number of consecutive conflicts the instruction side has lost so far.
    task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                                 input logic [AW-1:0] da, input logic [DW-1:0] dd,
                                 input logic [DW-1:0] rd);
        gnt_exp_t g;
        @(negedge clock);
        i_req     = ir;
        i_addr    = ia;
        d_req     = dr;
        d_we      = dw;
        d_addr    = da;
        d_wdata   = dd;
        ram_rdata = rd;
        stim_cycle++;

        g.i = 1'b0;
        g.d = 1'b0;
        if (ir && dr) begin
            n_conf++;
            if (lost_streak >= LIMIT) begin
                g.i         = 1'b1;
                lost_streak = 0;
            end else begin
                g.d         = 1'b1;
                lost_streak = (lost_streak + 1 > LIMIT) ? LIMIT : lost_streak + 1;
            end
        end else if (ir) begin
            g.i         = 1'b1;
            lost_streak = 0;
        end else if (dr) begin
            g.d = 1'b1;
        end
        g.addr  = g.i ? ia : (g.d ? da : '0);
        g.wen   = g.d && dw;
        g.wdata = dd;
        gnt_q.push_back(g);

        if (g.i) begin
            n_i++;
            resp_q.push_back('{is_i: 1'b1, data: rd, due: stim_cycle + 1});
        end
        if (g.d) begin
            n_d++;
            if (!dw) resp_q.push_back('{is_i: 1'b0, data: rd, due: stim_cycle + 1});
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, DW'($urandom));
    endtask

    task automatic randomCycle();
        applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    // Called just after a negedge with the monitor disabled; holds reset for a few cycles.
    task automatic resetPhase();
        reset     = 1'b1;
        i_req     = 1'b1;
        d_req     = 1'b1;
        d_we      = 1'b1;
        i_addr    = 16'h1234;
        d_addr    = 16'h5678;
        ram_rdata = 32'hA5A5A5A5;
        #1;
        checkOutput("rst_i_rvalid", 64'(i_rvalid), 64'd0);
        checkOutput("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        checkOutput("rst_i_rdata", 64'(i_rdata), 64'd0);
        checkOutput("rst_d_rdata", 64'(d_rdata), 64'd0);
        checkOutput("rst_i_gnt", 64'(i_gnt), 64'd0);
        checkOutput("rst_d_gnt", 64'(d_gnt), 64'd0);
        checkOutput("rst_ram_wEn", 64'(ram_wEn), 64'd0);
        checkOutput("rst_stat_i", 64'(stat_i_grants), 64'd0);
        checkOutput("rst_stat_d", 64'(stat_d_grants), 64'd0);
        checkOutput("rst_stat_c", 64'(stat_conflicts), 64'd0);
        gnt_q.delete();
        resp_q.delete();
        lost_streak = 0;
        last_i      = '0;
        last_d      = '0;
        n_i         = 0;
        n_d         = 0;
        n_conf      = 0;
        repeat (2) @(negedge clock);
        checkOutput("rst_held_gnt", 64'({i_gnt, d_gnt}), 64'd0);
        checkOutput("rst_held_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        reset      = 1'b0;
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        monitor_en = 1'b1;
    endtask

    // Monitor: grants are combinational in the current cycle, responses are due one cycle after their grant.
    initial begin
        gnt_exp_t  g;
        resp_exp_t r;
        forever begin
            @(negedge clock);
            #2;
            if (monitor_en) begin
                checkOutput("gnt_exclusive", 64'(i_gnt & d_gnt), 64'd0);
                if (gnt_q.size() > 0) begin
                    g = gnt_q.pop_front();
                    checkOutput("i_gnt", 64'(i_gnt), 64'(g.i));
                    checkOutput("d_gnt", 64'(d_gnt), 64'(g.d));
                    checkOutput("ram_addr", 64'(ram_addr), 64'(g.addr));
                    checkOutput("ram_wEn", 64'(ram_wEn), 64'(g.wen));
                    if (g.d) checkOutput("ram_wdata", 64'(ram_wdata), 64'(g.wdata));
                end
                if (i_rvalid || d_rvalid) begin
                    if (resp_q.size() == 0 || resp_q[0].due != stim_cycle) begin
                        checkOutput("unexpected_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
                    end else begin
                        r = resp_q.pop_front();
                        checkOutput("i_rvalid", 64'(i_rvalid), 64'(r.is_i));
                        checkOutput("d_rvalid", 64'(d_rvalid), 64'(!r.is_i));
                        if (r.is_i) begin
                            checkOutput("i_rdata", 64'(i_rdata), 64'(r.data));
                            last_i = r.data;
                        end else begin
                            checkOutput("d_rdata", 64'(d_rdata), 64'(r.data));
                            last_d = r.data;
                        end
                    end
                end else if (resp_q.size() > 0 && resp_q[0].due == stim_cycle) begin
                    r = resp_q.pop_front();
                    checkOutput("rvalid_missing", 64'({i_rvalid, d_rvalid}), r.is_i ? 64'd2 : 64'd1);
                end
                if (!i_rvalid) checkOutput("i_rdata_hold", 64'(i_rdata), 64'(last_i));
                if (!d_rvalid) checkOutput("d_rdata_hold", 64'(d_rdata), 64'(last_d));
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        stim_cycle   = 0;
        monitor_en   = 1'b0;
        reset        = 1'b1;
        i_req        = 1'b0;
        i_addr       = '0;
        d_req        = 1'b0;
        d_we         = 1'b0;
        d_addr       = '0;
        d_wdata      = '0;
        ram_rdata    = '0;

        @(negedge clock);
        resetPhase();

        // Instruction-only fetch, then a lone data write.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 32'hDEADBEEF);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h0100, 32'h12345678, 32'h0BADF00D);
        idleCycle();

        // Continuous conflicts from a cleared streak: D,D,D,D,I repeating.
        applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, '0, '0, 32'h11111111);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, AW'(16'h0400 + k), 1'b1, 1'b0, AW'(16'h0800 + k), '0, DW'($urandom));
        end

        // Alternating instruction/data reads, back to back.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k[0] == 1'b0, AW'($urandom), k[0] == 1'b1, 1'b0, AW'($urandom), '0, DW'($urandom));
        end

        for (int k = 0; k < 300; k++) randomCycle();

        // Data read grant, then reset in the response cycle.
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0200, '0, 32'hCAFEF00D);
        @(negedge clock);
        monitor_en = 1'b0;
        checkOutput("pre_reset_d_rvalid", 64'(d_rvalid), 64'd1);
        checkOutput("pre_reset_d_rdata", 64'(d_rdata), 64'hCAFEF00D);
        resetPhase();

        // Ten conflict reads straight out of reset.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, AW'($urandom), 1'b1, 1'b0, AW'($urandom), '0, DW'($urandom));
        end
        idleCycle();
        #1;
`ifdef MEM_ARB_STATS_EN
        checkOutput("stat_conflicts_10", 64'(stat_conflicts), 64'd10);
        checkOutput("stat_d_grants_10", 64'(stat_d_grants), 64'd8);
        checkOutput("stat_i_grants_10", 64'(stat_i_grants), 64'd2);
`else
        checkOutput("stat_conflicts_off", 64'(stat_conflicts), 64'd0);
        checkOutput("stat_d_grants_off", 64'(stat_d_grants), 64'd0);
        checkOutput("stat_i_grants_off", 64'(stat_i_grants), 64'd0);
`endif

        for (int k = 0; k < 200; k++) randomCycle();
        idleCycle();
        idleCycle();
        @(negedge clock);
        monitor_en = 1'b0;
        #3;
        checkOutput("resp_q_drained", 64'(resp_q.size()), 64'd0);
        checkOutput("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("stat_i_final", 64'(stat_i_grants), 64'(n_i));
        checkOutput("stat_d_final", 64'(stat_d_grants), 64'(n_d));
        checkOutput("stat_c_final", 64'(stat_conflicts), 64'(n_conf));
`else
        checkOutput("stat_i_final", 64'(stat_i_grants), 64'd0);
        checkOutput("stat_d_final", 64'(stat_d_grants), 64'd0);
        checkOutput("stat_c_final", 64'(stat_conflicts), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, sets the byte-address width in bits.
REQ-003 Parameter STARVE_LIMIT, default 4, sets how many consecutive lost conflicts force an instruction win; legal range 1..15.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  1  instruction-fetch request; held until granted.
REQ-007 i_addr  in  ADDR_WIDTH  instruction byte address.
REQ-008 i_gnt  out  1  instruction request accepted this cycle (combinational).
REQ-009 i_rvalid  out  1  instruction read data valid.
REQ-010 i_rdata  out  DATA_WIDTH  registered instruction read data.
REQ-011 d_req  in  1  data request; held until granted.
REQ-012 d_we  in  1  data request is a write.
REQ-013 d_addr  in  ADDR_WIDTH  data byte address.
REQ-014 d_wdata  in  DATA_WIDTH  write data.
REQ-015 d_gnt  out  1  data request accepted this cycle (combinational).
REQ-016 d_rvalid  out  1  data read data valid (reads only).
REQ-017 d_rdata  out  DATA_WIDTH  registered data read data.
REQ-018 ram_addr  out  ADDR_WIDTH  byte address to the shared RAM port.
REQ-019 ram_wEn  out  1  RAM write enable.
REQ-020 ram_wdata  out  DATA_WIDTH  RAM write data.
REQ-021 ram_rdata  in  DATA_WIDTH  combinational RAM read data.

Function
REQ-022 The block SHALL grant at most one requester per cycle: i_gnt and d_gnt are never both 1.
REQ-023 With a single requester active, that requester SHALL be granted in the same cycle.
REQ-024 On conflict (i_req and d_req both 1), data SHALL win unless starve_cnt has reached STARVE_LIMIT, in which case instruction wins.
REQ-025 The starvation counter starve_cnt (4 bits) SHALL behave as follows:
- increments, saturating at STARVE_LIMIT, on each conflict that instruction loses;
- clears on any instruction grant;
- holds otherwise.
REQ-026 The granted requester's address SHALL drive ram_addr in the grant cycle.
- ram_wEn = d_gnt & d_we.
- ram_wdata = d_wdata.
- With no grant: ram_addr = 0, ram_wEn = 0.
REQ-027 A read grant in cycle N SHALL capture ram_rdata into the owner's rdata register, with the matching rvalid high for exactly cycle N+1.
REQ-028 A data write SHALL complete in its grant cycle, and d_rvalid SHALL stay 0 for writes.
REQ-029 The owner FSM SHALL record the previous cycle's grant.
- States: IDLE, OWN_I, OWN_D.
- Next state: OWN_I on i_gnt; otherwise OWN_D on a d_gnt read; otherwise IDLE.
- i_rvalid = (state == OWN_I); d_rvalid = (state == OWN_D).
REQ-030 Back-to-back grants SHALL sustain one transaction per cycle with no bubble.
REQ-031 rdata registers SHALL hold their last value while the corresponding rvalid is 0.

Reset
REQ-032 Asserting reset SHALL, at any time, clear the following, dropping any in-flight response:
- state to IDLE;
- starve_cnt to 0;
- i_rdata and d_rdata to 0;
- i_rvalid and d_rvalid to 0.
REQ-033 While reset is high, i_gnt, d_gnt and ram_wEn SHALL be 0.

Configuration
REQ-034 With macro MEM_ARB_STATS_EN defined, the block SHALL add three 32-bit saturating outputs, all reset to 0:
- stat_i_grants: counts instruction grants;
- stat_d_grants: counts data grants;
- stat_conflicts: counts conflict cycles.
REQ-035 With MEM_ARB_STATS_EN undefined, these outputs SHALL exist but be tied to 0, and no counter logic SHALL be instantiated.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=0, OWN_I=1, OWN_D=2) and the default STARVE_LIMIT constant.
REQ-037 The starvation counter plus priority decision SHALL be one sub-module, arb_prio, which outputs the grant vector.

Verification
REQ-038 Instruction-only request, i_addr=0x0010, ram_rdata=0xDEADBEEF -> i_gnt=1 in cycle N; i_rvalid=1 and i_rdata=0xDEADBEEF in cycle N+1.
REQ-039 Data write d_addr=0x0100, d_wdata=0x12345678 -> d_gnt=1, ram_wEn=1, ram_addr=0x0100 in the same cycle; d_rvalid stays 0.
REQ-040 Both requesting continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; i_gnt every 5th cycle.
REQ-041 Reset asserted the cycle after a data read grant -> d_rvalid=0 immediately; all outputs at reset values.
REQ-042 Alternating I/D read requests on consecutive cycles -> one rvalid per cycle, each with the correct owner, no lost responses.
REQ-043 With MEM_ARB_STATS_EN defined, 10 conflict cycles -> stat_conflicts=10, stat_d_grants=8, stat_i_grants=2.
